// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with
// a 2-bit saturating counter per entry and a mispredict counter.
module branch_predictor #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] fetch_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  input  logic        res_mispred,
  output logic [31:0] mispred_count
);

  localparam int N = 1 << IDX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [29:0]      target;
    logic [1:0]       ctr;
  } btb_entry_t;

  localparam btb_entry_t ENTRY_RST = '{
    valid:  1'b0,
    tag:    '0,
    target: '0,
    ctr:    2'b01
  };

  btb_entry_t       table_q [N];
  btb_entry_t       look_ent;
  btb_entry_t       res_ent;
  btb_entry_t       upd_ent;
  logic             upd_en;
  logic [IDX_W-1:0] look_idx;
  logic [IDX_W-1:0] res_idx;
  logic [TAG_W-1:0] look_tag;
  logic [TAG_W-1:0] res_tag;
  logic             look_hit;
  logic             res_hit;
  logic [31:0]      mispred_q;
  logic             unused_bits;

  assign unused_bits = ^{res_pc[1:0], res_target[1:0]};

  assign look_idx = fetch_pc[IDX_W+1:2];
  assign look_tag = fetch_pc[31:IDX_W+2];
  assign res_idx  = res_pc[IDX_W+1:2];
  assign res_tag  = res_pc[31:IDX_W+2];

  // Lookup reads registered state only, so an update
  // in the same cycle is not seen until the next one.
  always_comb begin
    look_ent    = table_q[look_idx];
    look_hit    = look_ent.valid && (look_ent.tag == look_tag);
    pred_taken  = look_hit && look_ent.ctr[1];
    pred_target = look_hit ? {look_ent.target, 2'b00}
                           : fetch_pc + 32'd4;
  end

  // Next value of the resolving entry; not-taken misses
  // never allocate.
  always_comb begin
    res_ent = table_q[res_idx];
    res_hit = res_ent.valid && (res_ent.tag == res_tag);
    upd_ent = res_ent;
    upd_en  = 1'b0;
    unique case (1'b1)
      res_hit && res_taken: begin
        upd_en         = res_valid;
        upd_ent.target = res_target[31:2];
        if (res_ent.ctr != 2'b11)
          upd_ent.ctr = res_ent.ctr + 2'd1;
      end
      res_hit && !res_taken: begin
        upd_en = res_valid;
        if (res_ent.ctr != 2'b00)
          upd_ent.ctr = res_ent.ctr - 2'd1;
      end
      !res_hit && res_taken: begin
        upd_en         = res_valid;
        upd_ent.valid  = 1'b1;
        upd_ent.tag    = res_tag;
        upd_ent.target = res_target[31:2];
        upd_ent.ctr    = 2'b10;
      end
      default: begin
        upd_en = 1'b0;
      end
    endcase
  end

  // Table storage: cleared on reset, one entry written
  // per resolved branch.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int k = 0; k < N; k++)
        table_q[k] <= ENTRY_RST;
    end else if (upd_en) begin
      table_q[res_idx] <= upd_ent;
    end
  end

  // Misprediction counter, saturating at all-ones.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      mispred_q <= '0;
    else if (res_valid && res_mispred && mispred_q != '1)
      mispred_q <= mispred_q + 32'd1;
  end

  assign mispred_count = mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized self-checking bench for branch_predictor,
// compared against a per-index behavioural table model.
module tb_branch_predictor;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_taken;
  logic [31:0] res_target;
  logic        res_mispred;
  logic [31:0] mispred_count;

  int checks = 0;
  int failures = 0;

  bit          m_v   [16];
  int unsigned m_tag [16];
  int unsigned m_tgt [16];
  int          m_ctr [16];
  longint      m_cnt;

  branch_predictor dut (
    .CLK(CLK), .nRST(nRST),
    .fetch_pc(fetch_pc),
    .pred_taken(pred_taken),
    .pred_target(pred_target),
    .res_valid(res_valid), .res_pc(res_pc),
    .res_taken(res_taken), .res_target(res_target),
    .res_mispred(res_mispred),
    .mispred_count(mispred_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 16; k++) begin
      m_v[k] = 0; m_tag[k] = 0;
      m_tgt[k] = 0; m_ctr[k] = 1;
    end
    m_cnt = 0;
  endfunction

  function automatic int unsigned idx_of(int unsigned pc);
    return (pc / 4) % 16;
  endfunction

  function automatic int unsigned tag_of(int unsigned pc);
    return pc / 64;
  endfunction

  function automatic bit m_hit(int unsigned pc);
    return m_v[idx_of(pc)] && m_tag[idx_of(pc)] == tag_of(pc);
  endfunction

  // One cycle: drive, check lookup vs model, apply model update
  // after the edge. exp_t >= 0 adds an explicit taken check.
  task automatic step(input logic [31:0] f,
                      input logic rv, input logic [31:0] rpc,
                      input logic rt, input logic [31:0] rtg,
                      input logic rm, input int exp_t);
    int unsigned j;
    logic        e_t;
    logic [31:0] e_tg;
    @(negedge CLK);
    fetch_pc = f; res_valid = rv; res_pc = rpc;
    res_taken = rt; res_target = rtg; res_mispred = rm;
    #1;
    e_t  = m_hit(f) && m_ctr[idx_of(f)] >= 2;
    e_tg = m_hit(f) ? m_tgt[idx_of(f)] : f + 32'd4;
    check("pred_taken", {31'b0, pred_taken}, {31'b0, e_t});
    check("pred_target", pred_target, e_tg);
    check("mispred_count", mispred_count, m_cnt[31:0]);
    if (exp_t >= 0)
      check("pred_taken_exp", {31'b0, pred_taken}, exp_t);
    @(posedge CLK);
    if (rv) begin
      j = idx_of(rpc);
      if (m_hit(rpc)) begin
        if (rt) begin
          m_ctr[j] = (m_ctr[j] + 1 > 3) ? 3 : m_ctr[j] + 1;
          m_tgt[j] = rtg & ~32'd3;
        end else begin
          m_ctr[j] = (m_ctr[j] - 1 < 0) ? 0 : m_ctr[j] - 1;
        end
      end else if (rt) begin
        m_v[j] = 1; m_tag[j] = tag_of(rpc);
        m_tgt[j] = rtg & ~32'd3; m_ctr[j] = 2;
      end
      if (rm && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    end
  endtask

  task automatic probe(input logic [31:0] f, input int e);
    step(f, 0, $urandom, $urandom_range(1), $urandom,
         $urandom_range(1), e);
  endtask

  task automatic resolve(input logic [31:0] pc,
                         input logic t, input logic [31:0] tg);
    step(pc, 1, pc, t, tg, 0, -1);
  endtask

  // Asynchronous reset pulse while an update is being driven.
  task automatic pulse_reset(input logic [31:0] f);
    @(negedge CLK);
    fetch_pc = f; res_valid = 1; res_pc = 32'h40;
    res_taken = 1; res_target = 32'h300; res_mispred = 1;
    #2 nRST = 0;
    #1;
    model_reset();
    check("rst_taken", {31'b0, pred_taken}, 32'd0);
    check("rst_target", pred_target, f + 32'd4);
    check("rst_count", mispred_count, 32'd0);
    @(posedge CLK);
    #1;
    check("rst_hold_taken", {31'b0, pred_taken}, 32'd0);
    @(negedge CLK);
    res_valid = 0; res_mispred = 0;
    nRST = 1;
  endtask

  initial begin
    nRST = 1; fetch_pc = 32'h100;
    res_valid = 0; res_pc = 0; res_taken = 0;
    res_target = 0; res_mispred = 0;
    model_reset();
    pulse_reset(32'h100);

    // Allocate
    resolve(32'h40, 1, 32'h80);
    probe(32'h40, 1);
    check("alloc_target", pred_target, 32'h80);
    probe(32'h80, 0);

    // Saturation and hysteresis
    resolve(32'h40, 1, 32'h80);
    resolve(32'h40, 1, 32'h80);
    resolve(32'h40, 0, 32'h0);
    probe(32'h40, 1);
    resolve(32'h40, 0, 32'h0);
    probe(32'h40, 0);
    for (int k = 0; k < 3; k++) resolve(32'h40, 0, 32'h0);
    resolve(32'h40, 1, 32'h80);
    probe(32'h40, 0);

    // Alias replacement
    resolve(32'h440, 0, 32'h0);
    probe(32'h40, 0);
    check("alias_nt_hit", pred_target, 32'h80);
    resolve(32'h440, 1, 32'h200);
    probe(32'h40, 0);
    check("alias_miss_tgt", pred_target, 32'h44);
    probe(32'h440, 1);
    check("alias_new_tgt", pred_target, 32'h200);

    // Same-cycle lookup and update
    resolve(32'h40, 1, 32'h80);
    step(32'h40, 1, 32'h40, 0, 32'h0, 0, 1);
    probe(32'h40, 0);

    // Randomized traffic over a small PC pool
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pa, pb;
      pa = {$urandom_range(2), 6'b0} |
           ({28'b0, 4'($urandom_range(15))} << 2);
      pb = {$urandom_range(2), 6'b0} |
           ({28'b0, 4'($urandom_range(15))} << 2);
      step(pa, 1'($urandom_range(3) != 0), pb,
           1'($urandom_range(1)),
           $urandom | 32'($urandom_range(3)),
           1'($urandom_range(1)), -1);
    end

    // Mispredict counter
    pulse_reset(32'h20);
    for (int k = 0; k < 5; k++)
      step(32'h0, 1, 32'h8, 0, 0, 1, -1);
    probe(32'h0, -1);
    check("cnt_five", mispred_count, 32'd5);
    for (int k = 0; k < 3; k++)
      step(32'h0, 0, 32'h8, 1, 0, 1, -1);
    probe(32'h0, -1);
    check("cnt_hold", mispred_count, 32'd5);
    @(negedge CLK);
    force dut.mispred_q = 32'hFFFF_FFFE;
    #1 release dut.mispred_q;
    m_cnt = 64'hFFFF_FFFE;
    step(32'h0, 1, 32'h8, 0, 0, 1, -1);
    step(32'h0, 1, 32'h8, 0, 0, 1, -1);
    probe(32'h0, -1);
    check("cnt_sat", mispred_count, 32'hFFFF_FFFF);
    step(32'h0, 1, 32'h8, 0, 0, 1, -1);
    pulse_reset(32'h0);
    probe(32'h0, -1);
    check("cnt_cleared", mispred_count, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
